// File: rtl/alu_reservation_station.sv
// ALU reservation station. It holds dispatched ALU-class instructions until
// both source operands are known. Pending operands are captured from the ALU
// and load result broadcasts. At most one ready entry is issued per cycle,
// chosen round-robin, into a single-cycle ALU through registered issue_* outputs.
//
// Handshake: the block accepts a dispatch when have_ins_in is high, rdy_in is
// high and rs_full_out is low. A dispatch made while full is dropped. Issue
// has no backpressure: issue_have_ins is high for exactly one cycle for each
// instruction, and the issue_* fields hold their last value otherwise.
module alu_reservation_station #(
    parameter int RS_SIZE = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        have_ins_in,
    input  logic [2:0]  ins_id_in,
    input  logic [6:0]  opcode_in,
    input  logic [2:0]  funct3_in,
    input  logic [6:0]  funct7_in,
    input  logic [31:0] imm_in,
    input  logic [5:0]  shamt_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] rs1_val_in,
    input  logic [31:0] rs2_val_in,
    input  logic        rs1_pending_in,
    input  logic        rs2_pending_in,
    input  logic [2:0]  rs1_dep_in,
    input  logic [2:0]  rs2_dep_in,
    input  logic        alu_rdy_in,
    input  logic [31:0] alu_res_in,
    input  logic [2:0]  alu_res_ins_id_in,
    input  logic        lsb_rdy_in,
    input  logic [31:0] lsb_res_in,
    input  logic [2:0]  lsb_ins_id_in,
    output logic        rs_full_out,
    output logic        issue_have_ins,
    output logic [2:0]  issue_ins_id,
    output logic [6:0]  issue_opcode,
    output logic [2:0]  issue_funct3,
    output logic [6:0]  issue_funct7,
    output logic [31:0] issue_imm,
    output logic [5:0]  issue_shamt,
    output logic [31:0] issue_pc,
    output logic [31:0] issue_rs1_val,
    output logic [31:0] issue_rs2_val
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Per-entry storage
    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] rs1_pend;
    logic [RS_SIZE-1:0] rs2_pend;
    logic [2:0]         e_ins_id  [RS_SIZE];
    logic [6:0]         e_opcode  [RS_SIZE];
    logic [2:0]         e_funct3  [RS_SIZE];
    logic [6:0]         e_funct7  [RS_SIZE];
    logic [31:0]        e_imm     [RS_SIZE];
    logic [5:0]         e_shamt   [RS_SIZE];
    logic [31:0]        e_pc      [RS_SIZE];
    logic [31:0]        e_rs1_val [RS_SIZE];
    logic [31:0]        e_rs2_val [RS_SIZE];
    logic [2:0]         e_rs1_dep [RS_SIZE];
    logic [2:0]         e_rs2_dep [RS_SIZE];

    logic [IDX_W-1:0]   rr_ptr;
    logic               issued_last;
    logic               alu_bc_valid;
    logic               lsb_bc_valid;
    logic [RS_SIZE-1:0] eligible;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   rr_next;
    int                 cand;

    // The ALU raises alu_rdy_in on every active cycle. Its result is only real
    // in the cycle after this block has issued, so the broadcast is gated by issued_last.
    assign alu_bc_valid = alu_rdy_in && issued_last;
    assign lsb_bc_valid = lsb_rdy_in;
    assign rs_full_out  = &busy;
    assign eligible     = busy & ~rs1_pend & ~rs2_pend;
    assign rr_next      = (sel_idx == IDX_W'(RS_SIZE - 1)) ? '0 : sel_idx + IDX_W'(1);

    // Operand resolution against this cycle's broadcasts. The ALU wins a tie.
    function automatic logic [32:0] resolve(
        input logic        pend,
        input logic [2:0]  dep,
        input logic [31:0] val,
        input logic        alu_v,
        input logic [2:0]  alu_id,
        input logic [31:0] alu_res,
        input logic        lsb_v,
        input logic [2:0]  lsb_id,
        input logic [31:0] lsb_res
    );
        if (pend && alu_v && (dep == alu_id))      return {1'b0, alu_res};
        else if (pend && lsb_v && (dep == lsb_id)) return {1'b0, lsb_res};
        else                                       return {pend, val};
    endfunction

    // Find the lowest-index free entry for dispatch
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!free_found && !busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Round-robin search for the first eligible entry, starting at rr_ptr
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < RS_SIZE; k++) begin
            cand = (int'(rr_ptr) + k) % RS_SIZE;
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    // Entry state, snooping, dispatch, issue registers and round-robin pointer
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy           <= '0;
            rs1_pend       <= '0;
            rs2_pend       <= '0;
            rr_ptr         <= '0;
            issued_last    <= 1'b0;
            issue_have_ins <= 1'b0;
            issue_ins_id   <= '0;
            issue_opcode   <= '0;
            issue_funct3   <= '0;
            issue_funct7   <= '0;
            issue_imm      <= '0;
            issue_shamt    <= '0;
            issue_pc       <= '0;
            issue_rs1_val  <= '0;
            issue_rs2_val  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_ins_id[i]  <= '0;
                e_opcode[i]  <= '0;
                e_funct3[i]  <= '0;
                e_funct7[i]  <= '0;
                e_imm[i]     <= '0;
                e_shamt[i]   <= '0;
                e_pc[i]      <= '0;
                e_rs1_val[i] <= '0;
                e_rs2_val[i] <= '0;
                e_rs1_dep[i] <= '0;
                e_rs2_dep[i] <= '0;
            end
        end else if (!rdy_in) begin
            issue_have_ins <= 1'b0;
            issued_last    <= 1'b0;
        end else if (flush_pipline) begin
            busy           <= '0;
            issue_have_ins <= 1'b0;
            issued_last    <= 1'b0;
        end else begin
            issued_last <= issue_have_ins;

            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    {rs1_pend[i], e_rs1_val[i]} <= resolve(rs1_pend[i], e_rs1_dep[i], e_rs1_val[i],
                        alu_bc_valid, alu_res_ins_id_in, alu_res_in, lsb_bc_valid, lsb_ins_id_in, lsb_res_in);
                    {rs2_pend[i], e_rs2_val[i]} <= resolve(rs2_pend[i], e_rs2_dep[i], e_rs2_val[i],
                        alu_bc_valid, alu_res_ins_id_in, alu_res_in, lsb_bc_valid, lsb_ins_id_in, lsb_res_in);
                end
            end

            // The issued entry is busy, so it never collides with the dispatch slot
            if (sel_found) begin
                issue_have_ins <= 1'b1;
                issue_ins_id   <= e_ins_id[sel_idx];
                issue_opcode   <= e_opcode[sel_idx];
                issue_funct3   <= e_funct3[sel_idx];
                issue_funct7   <= e_funct7[sel_idx];
                issue_imm      <= e_imm[sel_idx];
                issue_shamt    <= e_shamt[sel_idx];
                issue_pc       <= e_pc[sel_idx];
                issue_rs1_val  <= e_rs1_val[sel_idx];
                issue_rs2_val  <= e_rs2_val[sel_idx];
                busy[sel_idx]  <= 1'b0;
                rr_ptr         <= rr_next;
            end else begin
                issue_have_ins <= 1'b0;
            end

            if (have_ins_in && !rs_full_out) begin
                busy[free_idx]      <= 1'b1;
                e_ins_id[free_idx]  <= ins_id_in;
                e_opcode[free_idx]  <= opcode_in;
                e_funct3[free_idx]  <= funct3_in;
                e_funct7[free_idx]  <= funct7_in;
                e_imm[free_idx]     <= imm_in;
                e_shamt[free_idx]   <= shamt_in;
                e_pc[free_idx]      <= pc_in;
                e_rs1_dep[free_idx] <= rs1_dep_in;
                e_rs2_dep[free_idx] <= rs2_dep_in;
                {rs1_pend[free_idx], e_rs1_val[free_idx]} <= resolve(rs1_pending_in, rs1_dep_in, rs1_val_in,
                    alu_bc_valid, alu_res_ins_id_in, alu_res_in, lsb_bc_valid, lsb_ins_id_in, lsb_res_in);
                {rs2_pend[free_idx], e_rs2_val[free_idx]} <= resolve(rs2_pending_in, rs2_dep_in, rs2_val_in,
                    alu_bc_valid, alu_res_ins_id_in, alu_res_in, lsb_bc_valid, lsb_ins_id_in, lsb_res_in);
            end
        end
    end
endmodule
